// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter sharing one 16-bit ROM fetch port between the 68000
// (program + extra code bank) and the Z80 sound ROM, one transaction at a time.
module rom_fetch_arbiter #(
  parameter int unsigned          ADDR_W         = 24,
  parameter logic [ADDR_W-1:0]    M68K_BASE      = 24'h000000,
  parameter logic [ADDR_W-1:0]    M68K_BANK2_OFS = 24'h040000,
  parameter logic [ADDR_W-1:0]    Z80_BASE       = 24'h080000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [23:0]       m68k_a,
  input  logic              m68k_rom_cs,
  input  logic              m68k_rom_2_cs,
  output logic [15:0]       m68k_rom_data,
  output logic              m68k_rom_valid,
  input  logic [15:0]       z80_addr,
  input  logic              z80_rom_cs,
  output logic [7:0]        z80_rom_data,
  output logic              z80_wait_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data
);

  // Memory handshake: mem_req rises with a frozen mem_addr and stays high
  // until the single-cycle mem_ack; mem_data is taken in the ack cycle.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_M68K_WAIT = 2'd1,
    S_Z80_WAIT  = 2'd2
  } state_t;

  localparam logic GRANT_M68K = 1'b0;
  localparam logic GRANT_Z80  = 1'b1;

  state_t             state;
  logic               last_grant;
  logic               m_served;
  logic               z_served;
  logic [15:0]        m_data;
  logic [15:0]        z_data;

  logic               m_cs;
  logic               m_pend;
  logic               z_pend;
  logic [ADDR_W-1:0]  m_addr_next;
  logic [ADDR_W-1:0]  z_addr_next;
  logic               unused_addr_bits;

  assign m_cs   = m68k_rom_cs | m68k_rom_2_cs;
  assign m_pend = m_cs & ~m_served & (state != S_M68K_WAIT);
  assign z_pend = z80_rom_cs & ~z_served & (state != S_Z80_WAIT);

  // Bank 2 wins if both chip selects are ever high together.
  always_comb begin
    m_addr_next = M68K_BASE + {{(ADDR_W-18){1'b0}}, m68k_a[17:1], 1'b0};
    if (m68k_rom_2_cs)
      m_addr_next = m_addr_next + M68K_BANK2_OFS;
    m_addr_next[0] = 1'b0;
    z_addr_next    = Z80_BASE + {{(ADDR_W-16){1'b0}}, z80_addr[15:1], 1'b0};
    z_addr_next[0] = 1'b0;
  end

  assign unused_addr_bits = &{1'b0, m68k_a[23:18], m68k_a[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      m_data     <= '0;
      z_data     <= '0;
      m_served   <= 1'b0;
      z_served   <= 1'b0;
      last_grant <= GRANT_Z80;
    end else begin
      if (!m_cs)       m_served <= 1'b0;
      if (!z80_rom_cs) z_served <= 1'b0;

      case (state)
        S_IDLE: begin
          // last_grant only moves on a tie, so it alternates who wins ties.
          if (m_pend && (!z_pend || last_grant == GRANT_Z80)) begin
            state    <= S_M68K_WAIT;
            mem_req  <= 1'b1;
            mem_addr <= m_addr_next;
            if (z_pend) last_grant <= GRANT_M68K;
          end else if (z_pend) begin
            state    <= S_Z80_WAIT;
            mem_req  <= 1'b1;
            mem_addr <= z_addr_next;
            if (m_pend) last_grant <= GRANT_Z80;
          end
        end
        S_M68K_WAIT: begin
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            if (m_cs) begin
              m_data   <= mem_data;
              m_served <= 1'b1;
            end
          end
        end
        S_Z80_WAIT: begin
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            if (z80_rom_cs) begin
              z_data   <= mem_data;
              z_served <= 1'b1;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign m68k_rom_data  = m_data;
  assign m68k_rom_valid = m_cs & m_served;
  assign z80_wait_n     = ~(z80_rom_cs & ~z_served);
  assign z80_rom_data   = z80_addr[0] ? z_data[15:8] : z_data[7:0];

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter: single fetches per requester, tie
// alternation, cancelled Z80 access and reset with a stale ack.
module tb_rom_fetch_arbiter;

  logic        clk;
  logic        reset;
  logic [23:0] m68k_a;
  logic        m68k_rom_cs;
  logic        m68k_rom_2_cs;
  logic [15:0] m68k_rom_data;
  logic        m68k_rom_valid;
  logic [15:0] z80_addr;
  logic        z80_rom_cs;
  logic [7:0]  z80_rom_data;
  logic        z80_wait_n;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_data;

  int checks   = 0;
  int failures = 0;

  rom_fetch_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .m68k_a         (m68k_a),
    .m68k_rom_cs    (m68k_rom_cs),
    .m68k_rom_2_cs  (m68k_rom_2_cs),
    .m68k_rom_data  (m68k_rom_data),
    .m68k_rom_valid (m68k_rom_valid),
    .z80_addr       (z80_addr),
    .z80_rom_cs     (z80_rom_cs),
    .z80_rom_data   (z80_rom_data),
    .z80_wait_n     (z80_wait_n),
    .mem_addr       (mem_addr),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .mem_data       (mem_data)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; outputs are read 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one-cycle ack pulse carrying data
  task automatic ack_pulse(input logic [15:0] d);
    mem_ack  = 1'b1;
    mem_data = d;
    tick();
    mem_ack  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; m68k_a = '0; m68k_rom_cs = 0; m68k_rom_2_cs = 0;
    z80_addr = '0; z80_rom_cs = 0; mem_ack = 0; mem_data = '0;
    tick(); tick();

    // reset state
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_valid", m68k_rom_valid, 0);
    check_eq("rst_wait_idle", z80_wait_n, 1);
    check_eq("rst_mdata", m68k_rom_data, 0);
    check_eq("rst_zdata", z80_rom_data, 0);
    z80_rom_cs = 1; #1;
    check_eq("rst_wait_cs", z80_wait_n, 0);
    z80_rom_cs = 0;
    reset = 0;
    tick();

    // single 68000 fetch, ack 3 cycles after req
    m68k_a = 24'h001234; m68k_rom_cs = 1;
    tick();
    check_eq("m1_req", mem_req, 1);
    check_eq("m1_addr", mem_addr, 24'h001234);
    check_eq("m1_valid_early", m68k_rom_valid, 0);
    tick(); tick(); tick();
    check_eq("m1_req_hold", mem_req, 1);
    check_eq("m1_addr_hold", mem_addr, 24'h001234);
    check_eq("m1_valid_wait", m68k_rom_valid, 0);
    ack_pulse(16'hBEEF);
    check_eq("m1_valid", m68k_rom_valid, 1);
    check_eq("m1_data", m68k_rom_data, 16'hBEEF);
    check_eq("m1_req_done", mem_req, 0);
    tick();
    check_eq("m1_no_refetch", mem_req, 0);
    m68k_rom_cs = 0;
    tick();
    check_eq("m1_valid_drop", m68k_rom_valid, 0);
    check_eq("m1_data_hold", m68k_rom_data, 16'hBEEF);

    // bank 2 fetch
    m68k_a = 24'h300010; m68k_rom_2_cs = 1;
    tick();
    check_eq("b2_addr", mem_addr, 24'h040010);
    check_eq("b2_req", mem_req, 1);
    ack_pulse(16'h1357);
    check_eq("b2_valid", m68k_rom_valid, 1);
    check_eq("b2_data", m68k_rom_data, 16'h1357);
    m68k_rom_2_cs = 0;
    tick();

    // Z80 fetch, odd address selects the high byte
    z80_addr = 16'h0101; z80_rom_cs = 1; #1;
    check_eq("z1_wait_n0", z80_wait_n, 0);
    tick();
    check_eq("z1_addr", mem_addr, 24'h080100);
    check_eq("z1_wait_n1", z80_wait_n, 0);
    tick();
    check_eq("z1_wait_n2", z80_wait_n, 0);
    ack_pulse(16'hA55A);
    check_eq("z1_wait_rel", z80_wait_n, 1);
    check_eq("z1_data_hi", z80_rom_data, 8'hA5);
    z80_addr = 16'h0100; #1;
    check_eq("z1_data_lo", z80_rom_data, 8'h5A);
    z80_rom_cs = 0;
    tick();

    // simultaneous requests: 68000 wins the first tie
    m68k_a = 24'h000100; m68k_rom_cs = 1;
    z80_addr = 16'h0002; z80_rom_cs = 1;
    tick();
    check_eq("t1_first_addr", mem_addr, 24'h000100);
    ack_pulse(16'h1111);
    check_eq("t1_idle_gap", mem_req, 0);
    check_eq("t1_m_valid", m68k_rom_valid, 1);
    check_eq("t1_m_data", m68k_rom_data, 16'h1111);
    check_eq("t1_z_waiting", z80_wait_n, 0);
    tick();
    check_eq("t1_second_req", mem_req, 1);
    check_eq("t1_second_addr", mem_addr, 24'h080002);
    ack_pulse(16'h2222);
    check_eq("t1_z_wait_rel", z80_wait_n, 1);
    check_eq("t1_z_data", z80_rom_data, 8'h22);
    m68k_rom_cs = 0; z80_rom_cs = 0;
    tick();

    // repeated tie: Z80 wins this time
    m68k_rom_cs = 1; z80_rom_cs = 1;
    tick();
    check_eq("t2_first_addr", mem_addr, 24'h080002);
    ack_pulse(16'h3344);
    check_eq("t2_idle_gap", mem_req, 0);
    check_eq("t2_m_valid_pend", m68k_rom_valid, 0);
    tick();
    check_eq("t2_second_addr", mem_addr, 24'h000100);
    ack_pulse(16'h5566);
    check_eq("t2_m_data", m68k_rom_data, 16'h5566);
    check_eq("t2_m_valid", m68k_rom_valid, 1);
    check_eq("t2_z_data", z80_rom_data, 8'h44);
    m68k_rom_cs = 0; z80_rom_cs = 0;
    tick();

    // Z80 access cancelled while waiting; 68000 pending behind it
    z80_addr = 16'h0010; z80_rom_cs = 1;
    tick();
    check_eq("c_addr", mem_addr, 24'h080010);
    z80_rom_cs = 0; m68k_a = 24'h000200; m68k_rom_cs = 1;
    tick();
    check_eq("c_req_frozen", mem_req, 1);
    check_eq("c_addr_frozen", mem_addr, 24'h080010);
    ack_pulse(16'h9999);
    check_eq("c_idle", mem_req, 0);
    check_eq("c_z_data_kept", z80_rom_data, 8'h44);
    check_eq("c_m_valid", m68k_rom_valid, 0);
    tick();
    check_eq("c_m_grant", mem_addr, 24'h000200);
    check_eq("c_m_req", mem_req, 1);
    ack_pulse(16'h7777);
    check_eq("c_m_data", m68k_rom_data, 16'h7777);
    z80_rom_cs = 1; #1;
    check_eq("c_z_not_served", z80_wait_n, 0);
    z80_rom_cs = 0; m68k_rom_cs = 0;
    tick();

    // reset in M68K_WAIT, then stale acks
    m68k_a = 24'h000400; m68k_rom_cs = 1;
    tick();
    check_eq("r_req_before", mem_req, 1);
    reset = 1;
    tick();
    check_eq("r_req_cleared", mem_req, 0);
    check_eq("r_addr_cleared", mem_addr, 0);
    check_eq("r_valid", m68k_rom_valid, 0);
    reset = 0; m68k_rom_cs = 0;
    ack_pulse(16'hDEAD);
    check_eq("r_stale_req", mem_req, 0);
    check_eq("r_stale_data", m68k_rom_data, 0);
    m68k_rom_cs = 1;
    ack_pulse(16'hDEAD);
    check_eq("r_stale2_req", mem_req, 1);
    check_eq("r_stale2_valid", m68k_rom_valid, 0);
    check_eq("r_stale2_data", m68k_rom_data, 0);
    tick();
    check_eq("r_req_held", mem_req, 1);
    ack_pulse(16'hCAFE);
    check_eq("r_final_valid", m68k_rom_valid, 1);
    check_eq("r_final_data", m68k_rom_data, 16'hCAFE);
    m68k_rom_cs = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
